pipe_hazard_ctrl: RTL and testbench

Stall/flush generator for the 5-stage pipeline. It drives the stall enables of the IF/ID pipeline registers (active-high load enable: 1 = load) and the flush input of the ID/EX register (active-high clear: 1 = insert bubble). It keeps its own shadow copies of the destination register and Tnew for the instructions in EX and MEM, plus a mult/div busy counter. From these it decides, each cycle, whether the instruction in ID must wait.

---
 rtl/pipe_hazard_ctrl_if.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bundle between the decode stage and the hazard unit.
// Master drives the ID instruction fields; slave returns stall/enables.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [1:0] id_rs_tuse;
  logic [1:0] id_rt_tuse;
  logic [4:0] id_waddr;
  logic [1:0] id_tnew;
  logic [1:0] id_md_op;
  logic       id_md_use;
  logic       stall;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_flush;
  logic       md_busy;
  logic [3:0] md_cnt;

  modport master (
    output id_rs,
    output id_rt,
    output id_rs_tuse,
    output id_rt_tuse,
    output id_waddr,
    output id_tnew,
    output id_md_op,
    output id_md_use,
    input  stall,
    input  pc_en,
    input  ifid_en,
    input  idex_flush,
    input  md_busy,
    input  md_cnt
  );

  modport slave (
    input  id_rs,
    input  id_rt,
    input  id_rs_tuse,
    input  id_rt_tuse,
    input  id_waddr,
    input  id_tnew,
    input  id_md_op,
    input  id_md_use,
    output stall,
    output pc_en,
    output ifid_en,
    output idex_flush,
    output md_busy,
    output md_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Tuse/Tnew stall and flush generator for the 5-stage pipeline.
// Shadows EX/MEM destinations and tracks the mult/div busy window.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] tnew;
  } shadow_t;

  shadow_t    ex_q;
  shadow_t    ex_d;
  shadow_t    mem_q;
  shadow_t    mem_d;
  logic [3:0] md_cnt_q;
  logic [3:0] md_cnt_d;

  logic rs_haz;
  logic rt_haz;
  logic md_haz;
  logic md_busy;
  logic stall;
  logic issue_mult;
  logic issue_div;
  logic md_dec;

  function automatic logic [1:0] sat_dec(
    input logic [1:0] t
  );
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Tuse 3 means the source is unused; $0 never aliases a producer.
  function automatic logic src_haz(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input shadow_t    s
  );
    return (src != 5'd0)
        && (tuse != 2'd3)
        && (src == s.waddr)
        && (tuse < s.tnew);
  endfunction

  always_comb begin
    rs_haz = src_haz(hz.id_rs, hz.id_rs_tuse, ex_q)
           | src_haz(hz.id_rs, hz.id_rs_tuse, mem_q);
    rt_haz = src_haz(hz.id_rt, hz.id_rt_tuse, ex_q)
           | src_haz(hz.id_rt, hz.id_rt_tuse, mem_q);
    md_busy = (md_cnt_q != 4'd0);
    md_haz  = hz.id_md_use & md_busy;
    stall   = rs_haz | rt_haz | md_haz;
  end

  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.waddr = hz.id_waddr;
      ex_d.tnew  = hz.id_tnew;
    end
    mem_d.waddr = ex_q.waddr;
    mem_d.tnew  = sat_dec(ex_q.tnew);
  end

  // A stalled MD op never reaches EX, so it must not arm the counter.
  always_comb begin
    issue_mult = ~stall & (hz.id_md_op == 2'b01);
    issue_div  = ~stall & (hz.id_md_op == 2'b10);
    md_dec     = ~issue_mult & ~issue_div & md_busy;
    md_cnt_d   = 4'd0;
    unique case (1'b1)
      issue_mult: md_cnt_d = MULT_LD;
      issue_div:  md_cnt_d = DIV_LD;
      md_dec:     md_cnt_d = md_cnt_q - 4'd1;
      default:    md_cnt_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      md_cnt_q <= 4'd0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign hz.stall      = stall;
  assign hz.pc_en      = ~stall;
  assign hz.ifid_en    = ~stall;
  assign hz.idex_flush = stall;
  assign hz.md_busy    = md_busy;
  assign hz.md_cnt     = md_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked against an issue-history model of the pipeline.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(
    .MULT_CYC(5),
    .DIV_CYC (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0] waddr;
    int         tnew;
    int         cyc;
  } iss_t;

  iss_t hist[$];
  int   now      = 0;
  int   md_issue = -100;
  int   md_lat   = 0;

  function automatic int m_mdcnt();
    int r;
    if (now <= md_issue) return 0;
    r = md_lat - (now - md_issue - 1);
    return (r < 0) ? 0 : r;
  endfunction

  // An instruction issued at cycle c sits in EX at c+1 and MEM at c+2,
  // its remaining Tnew dropping by one per stage and floored at zero.
  function automatic bit m_stall();
    bit s = 0;
    foreach (hist[i]) begin
      int age = now - hist[i].cyc;
      int t;
      if ((age == 1 || age == 2) && hist[i].waddr != 0) begin
        t = hist[i].tnew - (age - 1);
        if (t < 0) t = 0;
        if (hz.id_rs == hist[i].waddr && int'(hz.id_rs_tuse) < t) s = 1;
        if (hz.id_rt == hist[i].waddr && int'(hz.id_rt_tuse) < t) s = 1;
      end
    end
    if (hz.id_md_use && m_mdcnt() != 0) s = 1;
    return s;
  endfunction

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] rsu, input logic [1:0] rtu,
                     input logic [4:0] wa, input logic [1:0] tn,
                     input logic [1:0] op, input logic use_md);
    hz.id_rs = rs; hz.id_rt = rt;
    hz.id_rs_tuse = rsu; hz.id_rt_tuse = rtu;
    hz.id_waddr = wa; hz.id_tnew = tn;
    hz.id_md_op = op; hz.id_md_use = use_md;
    #1;
  endtask

  task automatic tick();
    bit         s;
    bit         r;
    iss_t       e;
    logic [1:0] op;
    s = m_stall();
    r = reset;
    e.waddr = hz.id_waddr;
    e.tnew  = int'(hz.id_tnew);
    e.cyc   = now;
    op = hz.id_md_op;
    @(posedge clk);
    if (r) begin
      hist.delete();
      md_lat = 0;
      md_issue = -100;
    end else if (!s) begin
      hist.push_back(e);
      if (op == 2'b01) begin md_issue = now; md_lat = 5; end
      else if (op == 2'b10) begin md_issue = now; md_lat = 10; end
    end
    now++;
    while (hist.size() > 0 && now - hist[0].cyc > 2)
      void'(hist.pop_front());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drv(0, 0, 3, 3, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    n_chk++; if (hz.stall !== 1'b0) begin n_fail++;
      $display("FAIL rst_stall: got %b want 0", hz.stall); end
    n_chk++; if (hz.pc_en !== 1'b1) begin n_fail++;
      $display("FAIL rst_pc_en: got %b want 1", hz.pc_en); end
    n_chk++; if (hz.ifid_en !== 1'b1) begin n_fail++;
      $display("FAIL rst_ifid_en: got %b want 1", hz.ifid_en); end
    n_chk++; if (hz.idex_flush !== 1'b0) begin n_fail++;
      $display("FAIL rst_flush: got %b want 0", hz.idex_flush); end
    n_chk++; if (hz.md_busy !== 1'b0 || hz.md_cnt !== 4'd0) begin n_fail++;
      $display("FAIL rst_md: got busy %b cnt %0d want 0 0", hz.md_busy, hz.md_cnt); end
  endtask

  task automatic test_load_use();
    idle(2);
    drv(0, 0, 3, 3, 8, 2, 0, 0);
    n_chk++; if (hz.stall !== 1'b0) begin n_fail++;
      $display("FAIL lu_load: got %b want 0", hz.stall); end
    tick();
    drv(8, 0, 1, 3, 9, 1, 0, 0);
    n_chk++; if (hz.stall !== 1'b1 || hz.idex_flush !== 1'b1 || hz.pc_en !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_c1: got stall %b flush %b pc_en %b want 1 1 0",
               hz.stall, hz.idex_flush, hz.pc_en); end
    tick(); #1;
    n_chk++; if (hz.stall !== 1'b0 || hz.idex_flush !== 1'b0 || hz.ifid_en !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_c2: got stall %b flush %b ifid %b want 0 0 1",
               hz.stall, hz.idex_flush, hz.ifid_en); end
    tick();
  endtask

  task automatic test_load_branch();
    int exp_s[3] = '{1, 1, 0};
    idle(3);
    drv(0, 0, 3, 3, 8, 2, 0, 0);
    tick();
    drv(8, 0, 0, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (hz.stall !== 1'(exp_s[i])) begin n_fail++;
        $display("FAIL lb_c%0d: got %b want %0d", i, hz.stall, exp_s[i]); end
      tick(); #1;
    end
    idle(3);
    drv(0, 0, 3, 3, 0, 2, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (hz.stall !== 1'b0) begin n_fail++;
      $display("FAIL lb_zero: got %b want 0", hz.stall); end
    idle(2);
    drv(0, 0, 3, 3, 7, 1, 0, 0);
    tick();
    drv(0, 7, 3, 0, 0, 0, 0, 0);
    n_chk++; if (hz.stall !== 1'b1) begin n_fail++;
      $display("FAIL ab_c0: got %b want 1", hz.stall); end
    tick(); #1;
    n_chk++; if (hz.stall !== 1'b0) begin n_fail++;
      $display("FAIL ab_c1: got %b want 0", hz.stall); end
    tick();
  endtask

  task automatic test_div_mflo();
    idle(3);
    drv(0, 0, 3, 3, 0, 0, 2'b10, 1);
    n_chk++; if (hz.stall !== 1'b0) begin n_fail++;
      $display("FAIL div_issue: got %b want 0", hz.stall); end
    tick();
    drv(0, 0, 3, 3, 2, 1, 2'b00, 1);
    for (int k = 10; k >= 1; k--) begin
      n_chk++; if (hz.md_cnt !== 4'(k) || hz.stall !== 1'b1 || hz.md_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL div_cnt%0d: got cnt %0d stall %b busy %b want %0d 1 1",
                 k, hz.md_cnt, hz.stall, hz.md_busy, k); end
      tick(); #1;
    end
    n_chk++; if (hz.md_cnt !== 4'd0 || hz.stall !== 1'b0) begin n_fail++;
      $display("FAIL div_rel: got cnt %0d stall %b want 0 0", hz.md_cnt, hz.stall); end
    tick();
  endtask

  task automatic test_mult_reset();
    idle(3);
    drv(0, 0, 3, 3, 0, 0, 2'b01, 1);
    tick();
    drv(0, 0, 3, 3, 0, 0, 2'b01, 1);
    n_chk++; if (hz.md_cnt !== 4'd5 || hz.stall !== 1'b1) begin n_fail++;
      $display("FAIL mult_b2b: got cnt %0d stall %b want 5 1", hz.md_cnt, hz.stall); end
    tick(); tick();
    drv(0, 0, 3, 3, 3, 1, 2'b00, 1);
    n_chk++; if (hz.md_cnt !== 4'd3 || hz.stall !== 1'b1) begin n_fail++;
      $display("FAIL mult_c3: got cnt %0d stall %b want 3 1", hz.md_cnt, hz.stall); end
    reset = 1'b1; #1;
    n_chk++; if (hz.stall !== 1'b1) begin n_fail++;
      $display("FAIL mult_rst_comb: got %b want 1", hz.stall); end
    tick();
    reset = 1'b0; #1;
    n_chk++; if (hz.md_cnt !== 4'd0 || hz.md_busy !== 1'b0 || hz.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_rst: got cnt %0d busy %b stall %b want 0 0 0",
               hz.md_cnt, hz.md_busy, hz.stall); end
    tick();
  endtask

  task automatic test_no_hazard();
    idle(3);
    drv(0, 0, 3, 3, 8, 2, 0, 0);
    tick();
    drv(8, 8, 3, 3, 0, 0, 0, 0);
    n_chk++; if (hz.stall !== 1'b0) begin n_fail++;
      $display("FAIL nh_tuse3: got %b want 0", hz.stall); end
    idle(3);
    drv(0, 0, 3, 3, 9, 2, 0, 0);
    tick();
    drv(0, 0, 3, 3, 0, 0, 0, 0);
    tick();
    drv(0, 9, 3, 1, 0, 0, 0, 0);
    n_chk++; if (hz.stall !== 1'b0) begin n_fail++;
      $display("FAIL nh_mem_eq: got %b want 0", hz.stall); end
    drv(0, 9, 3, 0, 0, 0, 0, 0);
    n_chk++; if (hz.stall !== 1'b1) begin n_fail++;
      $display("FAIL nh_mem_lt: got %b want 1", hz.stall); end
    tick();
  endtask

  task automatic test_random();
    bit es;
    int em;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      reset = ($urandom_range(0, 59) == 0);
      drv(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          2'($urandom), 2'($urandom),
          5'($urandom_range(0, 3)), 2'($urandom),
          op, (op != 2'b00) | ($urandom_range(0, 3) == 0));
      es = m_stall();
      em = m_mdcnt();
      n_chk++; if (hz.stall !== es || hz.idex_flush !== es) begin n_fail++;
        $display("FAIL rnd_stall c%0d: got %b/%b want %b",
                 c, hz.stall, hz.idex_flush, es); end
      n_chk++; if (hz.pc_en !== !es || hz.ifid_en !== !es) begin n_fail++;
        $display("FAIL rnd_en c%0d: got %b/%b want %b",
                 c, hz.pc_en, hz.ifid_en, !es); end
      n_chk++; if (hz.md_cnt !== 4'(em) || hz.md_busy !== (em != 0)) begin n_fail++;
        $display("FAIL rnd_md c%0d: got cnt %0d busy %b want %0d",
                 c, hz.md_cnt, hz.md_busy, em); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_div_mflo();
    test_mult_reset();
    test_no_hazard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
